// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the core's single-cycle MEM-stage data access into a
// valid/ready request plus rvalid response on an external memory bus. It holds
// the pipeline stall high until the access completes, and it aborts reads
// that see no response within TIMEOUT cycles.
// Optional feature: define DMEM_BRIDGE_POSTED_WR_EN to post stores into a
// one-entry write buffer so the core does not wait for them.
module dmem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // The counter only needs to hold 0 .. TIMEOUT-1; the abort fires on the
    // cycle it would reach TIMEOUT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef DMEM_BRIDGE_POSTED_WR_EN
    logic             posted_q, posted_d;
`endif

    logic req;
    logic unused_addr_bits;

    // A write wins when both strobes are set, so req only needs the OR.
    assign req              = cpu_read | cpu_write;
    assign unused_addr_bits = ^cpu_addr[1:0];

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; all storage here is plain flops, each given
    // an explicit reset value so no stale request can reach the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef DMEM_BRIDGE_POSTED_WR_EN
            posted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
`ifdef DMEM_BRIDGE_POSTED_WR_EN
            posted_q <= posted_d;
`endif
        end
    end

    // Next-state logic: start on a fresh request, leave REQ on acceptance,
    // leave RESP on a response or on timeout.
    // NOTE: each always_comb assigns a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req && !done_q) state_d = S_REQ;
            S_REQ:  if (bus_ready) state_d = we_q ? S_IDLE : S_RESP;
            S_RESP: if (bus_rvalid || cnt_q == CNT_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: request capture, response capture, timeout count.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
`ifdef DMEM_BRIDGE_POSTED_WR_EN
        posted_d = posted_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (done_q) begin
                    // Completion cycle: the core advances, nothing new starts.
                    done_d = 1'b0;
                end else if (req) begin
                    addr_d   = cpu_addr[31:2];
                    wdata_d  = cpu_wdata;
                    we_d     = cpu_write;
`ifdef DMEM_BRIDGE_POSTED_WR_EN
                    posted_d = cpu_write;
`endif
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    if (we_q) begin
`ifdef DMEM_BRIDGE_POSTED_WR_EN
                        // A posted store already released the core.
                        done_d   = ~posted_q;
                        posted_d = 1'b0;
`else
                        done_d   = 1'b1;
`endif
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            S_RESP: begin
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: request valid while in REQ, and the pipeline stall.
    always_comb begin
        bus_valid = (state_q == S_REQ);
`ifdef DMEM_BRIDGE_POSTED_WR_EN
        // While the buffer drains, only a new access has to wait; a store
        // found in IDLE is posted without stalling.
        stall = posted_q ? req
                         : ((state_q != S_IDLE) | (req & ~done_q & ~cpu_write));
`else
        stall = (state_q != S_IDLE) | (req & ~done_q);
`endif
    end

    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge. The bench plays both the core and the
// memory bus. Each access is described at transaction level (type, bus delays,
// data), and the expected bus timing, stall window, returned data and error
// flag are derived from those numbers with plain arithmetic.
`timescale 1ns/1ps
module tb_dmem_bridge;

    localparam int unsigned TO       = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
`ifdef DMEM_BRIDGE_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_read, cpu_write, stall;
    logic        bus_valid, bus_ready, bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_rvalid, err;

    dmem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR_DATA)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: last data the core should see, and the sticky error.
    logic [31:0] last_rdata_m;
    logic        err_m;

    // Accepted bus requests in order, as {we, word address}.
    logic [30:0] acc_q[$];

    always @(negedge clk)
        if (rst === 1'b0 && bus_valid === 1'b1 && bus_ready === 1'b1)
            acc_q.push_back({bus_we, bus_addr});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (required: bench ends earlier)");
        $fatal(1);
    end

    // One core access from request cycle (k=0) through the completion cycle.
    // Timeline for a non-posted access: k=0 request in IDLE, k=1..acc_k in REQ
    // (accepted at acc_k), then resp_cycles in RESP, then the done cycle.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int rdy_dly,
                             input int rv_dly, input logic [31:0] rdata,
                             input string name);
        bit          is_wr, timeout;
        int          resp_cycles, acc_k, bus_end, exp_done, rv_k, got_done;
        int          valid_bad, field_bad, stall_bad;
        logic [31:0] exp_rdata, rdata_at_done;
        is_wr       = wr;
        timeout     = !is_wr && (rv_dly >= int'(TO));
        resp_cycles = is_wr ? 0 : (timeout ? int'(TO) : rv_dly + 1);
        acc_k       = 1 + rdy_dly;
        rv_k        = acc_k + 1 + rv_dly;
        bus_end     = acc_k + resp_cycles;
        exp_done    = (POSTED && is_wr) ? 0 : bus_end + 1;
        exp_rdata   = is_wr ? last_rdata_m : (timeout ? ERR_DATA : rdata);
        got_done = -1; valid_bad = 0; field_bad = 0; stall_bad = 0;
        rdata_at_done = 'x;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int k = 0; k <= bus_end + 1; k++) begin
            cpu_read  = (got_done < 0) ? rd : 1'b0;
            cpu_write = (got_done < 0) ? wr : 1'b0;
            if (k == acc_k)               bus_ready = 1'b1;
            else if (k > 0 && k < acc_k)  bus_ready = 1'b0;
            else                          bus_ready = 1'($urandom_range(1));
            if (!is_wr && k > acc_k && k <= bus_end)
                bus_rvalid = !timeout && (k == rv_k);
            else
                bus_rvalid = 1'($urandom_range(1));
            bus_rdata = (k == rv_k) ? rdata : $urandom();
            @(negedge clk);
            if (bus_valid !== (k >= 1 && k <= acc_k)) valid_bad++;
            if (bus_valid === 1'b1 &&
                (bus_we !== is_wr || bus_addr !== addr[31:2] || bus_wdata !== wdata))
                field_bad++;
            if (stall !== (k < exp_done)) stall_bad++;
            if (got_done < 0 && stall === 1'b0) got_done = k;
            if (k == exp_done) rdata_at_done = cpu_rdata;
            @(posedge clk); #1;
        end
        if (!is_wr) last_rdata_m = exp_rdata;
        if (timeout) err_m = 1'b1;

        n_cmp++;
        if (valid_bad != 0) begin
            n_bad++;
            $display("FAIL %s bus_valid: wrong in %0d cycles, required high exactly in cycles 1..%0d",
                     name, valid_bad, acc_k);
        end
        n_cmp++;
        if (field_bad != 0) begin
            n_bad++;
            $display("FAIL %s bus fields: %0d bad cycles (we=%b addr=%h wdata=%h), required we=%b addr=%h wdata=%h",
                     name, field_bad, bus_we, bus_addr, bus_wdata, is_wr, addr[31:2], wdata);
        end
        n_cmp++;
        if (stall_bad != 0 || got_done != exp_done) begin
            n_bad++;
            $display("FAIL %s stall: released in cycle %0d (%0d bad cycles), required release in cycle %0d",
                     name, got_done, stall_bad, exp_done);
        end
        n_cmp++;
        if (rdata_at_done !== exp_rdata) begin
            n_bad++;
            $display("FAIL %s cpu_rdata: got %h, required %h", name, rdata_at_done, exp_rdata);
        end
        n_cmp++;
        if (err !== err_m) begin
            n_bad++;
            $display("FAIL %s err: got %b, required %b", name, err, err_m);
        end

        // One quiet cycle with stray bus handshakes that must be ignored.
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        bus_ready  = 1'($urandom_range(1));
        bus_rvalid = 1'($urandom_range(1));
        bus_rdata  = $urandom();
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || bus_valid !== 1'b0 || cpu_rdata !== last_rdata_m) begin
            n_bad++;
            $display("FAIL %s idle: stall=%b bus_valid=%b cpu_rdata=%h, required 0 0 %h",
                     name, stall, bus_valid, cpu_rdata, last_rdata_m);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        last_rdata_m = '0;
        err_m = 1'b0;
        #2;
        n_cmp++;
        if (bus_valid !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 30'h0 || bus_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset bus: valid=%b we=%b addr=%h wdata=%h, required all 0",
                     bus_valid, bus_we, bus_addr, bus_wdata);
        end
        n_cmp++;
        if (cpu_rdata !== 32'h0 || err !== 1'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset core: rdata=%h err=%b stall=%b, required 0 0 0", cpu_rdata, err, stall);
        end
        cpu_read = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL reset stall_with_req: got %b, required 1", stall);
        end
        cpu_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall !== 1'b0 || bus_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset release: stall=%b bus_valid=%b, required 0 0", stall, bus_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 0, 32'h1234_5678, "read_min");
        do_access(1'b1, 1'b0, 32'h0000_0ABF, 32'h0, 2, 1, 32'h0BAD_CAFE, "read_slow");
    endtask

    task automatic test_write();
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 3, 0, 32'h0, "write_delay3");
        do_access(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0F0F_1234, 0, 0, 32'h0, "write_min");
    endtask

    task automatic test_read_write_both();
        do_access(1'b1, 1'b1, 32'h0000_0300, 32'h7777_8888, 1, 0, 32'h5555_AAAA, "both_strobes");
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 1, int'(TO) + 3, 32'h1111_1111, "timeout");
        do_access(1'b1, 1'b0, 32'h0000_0408, 32'h0, 0, 0, 32'h2222_2222, "after_timeout");
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b, required 1", err);
        end
    endtask

    task automatic test_store_load();
        acc_q.delete();
`ifdef DMEM_BRIDGE_POSTED_WR_EN
        begin
            // Store posted at k=0; load from k=1 waits for the drain
            // (accepted at k=3), then REQ k=5, RESP k=6, done k=7.
            bit exp_st [8];
            int stall_bad;
            exp_st = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            stall_bad = 0;
            for (int k = 0; k < 8; k++) begin
                cpu_write  = (k == 0);
                cpu_read   = (k >= 1);
                cpu_addr   = (k == 0) ? 32'h40 : 32'h44;
                cpu_wdata  = (k == 0) ? 32'h1111_2222 : 32'h0;
                bus_ready  = (k == 3 || k == 5);
                bus_rvalid = (k == 6);
                bus_rdata  = (k == 6) ? 32'hCAFE_F00D : $urandom();
                @(negedge clk);
                if (stall !== exp_st[k]) stall_bad++;
                if (k == 7) begin
                    n_cmp++;
                    if (cpu_rdata !== 32'hCAFE_F00D) begin
                        n_bad++;
                        $display("FAIL posted_load rdata: got %h, required cafef00d", cpu_rdata);
                    end
                end
                @(posedge clk); #1;
            end
            last_rdata_m = 32'hCAFE_F00D;
            n_cmp++;
            if (stall_bad != 0) begin
                n_bad++;
                $display("FAIL posted_stall: %0d cycles wrong, required 0", stall_bad);
            end
            cpu_read = 1'b0; cpu_write = 1'b0;
            bus_ready = 1'b0; bus_rvalid = 1'b0;
            @(posedge clk); #1;
        end
`else
        do_access(1'b0, 1'b1, 32'h40, 32'h1111_2222, 2, 0, 32'h0, "sl_store");
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 0, 0, 32'hCAFE_F00D, "sl_load");
`endif
        n_cmp++;
        if (acc_q.size() != 2 || acc_q[0] !== {1'b1, 30'h10} || acc_q[1] !== {1'b0, 30'h11}) begin
            n_bad++;
            $display("FAIL bus_order: %0d accepts (first %h), required 2: %h then %h",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 31'h0,
                     {1'b1, 30'h10}, {1'b0, 30'h11});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = int'($urandom_range(2));
            do_access(kind != 1, kind != 0, $urandom(), $urandom(),
                      int'($urandom_range(3)), int'($urandom_range(TO + 1)),
                      $urandom(), "random");
        end
    endtask

    task automatic test_reset_mid_txn();
        // Make sure cpu_rdata is non-zero before the reset.
        do_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 0, 0, 32'h5A5A_0001, "pre_reset_read");

        // Reset while waiting in RESP.
        cpu_read = 1'b1; cpu_addr = 32'h0000_0600;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        @(posedge clk); #1;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        #1;
        rst = 1'b1;
        cpu_read = 1'b0;
        #1;
        last_rdata_m = '0;
        err_m = 1'b0;
        n_cmp++;
        if (bus_valid !== 1'b0 || stall !== 1'b0 || cpu_rdata !== 32'h0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_in_resp: valid=%b stall=%b rdata=%h err=%b, required 0 0 0 0",
                     bus_valid, stall, cpu_rdata, err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus_rvalid = 1'b1;
            bus_ready  = 1'($urandom_range(1));
            bus_rdata  = $urandom() | 32'h1;
            @(negedge clk);
            n_cmp++;
            if (cpu_rdata !== 32'h0 || stall !== 1'b0 || bus_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL late_rvalid: rdata=%h stall=%b valid=%b, required 0 0 0",
                         cpu_rdata, stall, bus_valid);
            end
            @(posedge clk); #1;
        end
        bus_rvalid = 1'b0; bus_ready = 1'b0;

        // Reset while requesting in REQ, with the core still asking.
        cpu_read = 1'b1; cpu_addr = 32'h0000_0700;
        @(posedge clk); #1;
        n_cmp++;
        if (bus_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL req_before_rst: bus_valid=%b, required 1", bus_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus_valid !== 1'b0 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_in_req: valid=%b stall=%b, required 0 1", bus_valid, stall);
        end
        cpu_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'h0000_0804, 32'h0, 1, 2, 32'h600D_DA7A, "post_reset_read");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_read_write_both();
        test_timeout();
        test_store_load();
        test_random();
        test_reset_mid_txn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
